// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: opcode/handshake inputs and datapath controls of the multicycle control FSM.
interface multicycle_control_unit_if #(
   parameter int OPCODE_WIDTH = 6,
   parameter int STATE_WIDTH  = 4
);
   logic [OPCODE_WIDTH-1:0] op;
   logic                    mem_ready;
   logic                    pcwrite;
   logic                    pcwritecond;
   logic                    iord;
   logic                    memread;
   logic                    memwrite;
   logic                    irwrite;
   logic                    memtoreg;
   logic                    regdst;
   logic                    regwrite;
   logic                    alusrca;
   logic [1:0]              alusrcb;
   logic [1:0]              aluop;
   logic [1:0]              pcsource;
   logic                    instr_done;
   logic                    illegal_op;
   logic [STATE_WIDTH-1:0]  state;
   modport master (
      input  op, mem_ready,
      output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
             regwrite, alusrca, alusrcb, aluop, pcsource, instr_done, illegal_op, state
   );
   modport slave (
      output op, mem_ready,
      input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
             regwrite, alusrca, alusrcb, aluop, pcsource, instr_done, illegal_op, state
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore control FSM sequencing the multicycle MIPS datapath.
// Define JUMP_EN to decode j (000010) into the JUMP state; otherwise j is an illegal opcode.
module multicycle_control_unit #(
   parameter int OPCODE_WIDTH = 6,
   parameter int STATE_WIDTH  = 4
) (
   input logic                       clk,
   input logic                       rst_n,
   multicycle_control_unit_if.master bus
);
   localparam logic [STATE_WIDTH-1:0] FETCH  = STATE_WIDTH'(0);
   localparam logic [STATE_WIDTH-1:0] DECODE = STATE_WIDTH'(1);
   localparam logic [STATE_WIDTH-1:0] MEMADR = STATE_WIDTH'(2);
   localparam logic [STATE_WIDTH-1:0] MEMRD  = STATE_WIDTH'(3);
   localparam logic [STATE_WIDTH-1:0] MEMWB  = STATE_WIDTH'(4);
   localparam logic [STATE_WIDTH-1:0] MEMWR  = STATE_WIDTH'(5);
   localparam logic [STATE_WIDTH-1:0] EXEC   = STATE_WIDTH'(6);
   localparam logic [STATE_WIDTH-1:0] RWB    = STATE_WIDTH'(7);
   localparam logic [STATE_WIDTH-1:0] BRANCH = STATE_WIDTH'(8);
   localparam logic [STATE_WIDTH-1:0] ADDIEX = STATE_WIDTH'(10);
   localparam logic [STATE_WIDTH-1:0] ADDIWB = STATE_WIDTH'(11);
   localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
   localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
   localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
`ifdef JUMP_EN
   localparam logic [STATE_WIDTH-1:0]  JUMP = STATE_WIDTH'(9);
   localparam logic [OPCODE_WIDTH-1:0] OP_J = OPCODE_WIDTH'(6'b000010);
`endif
   logic [STATE_WIDTH-1:0] state_q;
   logic [STATE_WIDTH-1:0] state_d;
   logic [STATE_WIDTH-1:0] decode_tail;
   logic legal_op;
   logic in_fetch, in_decode, in_memadr, in_memrd, in_memwb, in_memwr;
   logic in_exec, in_rwb, in_branch, in_jump, in_addiex, in_addiwb;
   logic illegal;
`ifdef JUMP_EN
   assign legal_op    = bus.op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
   assign decode_tail = (bus.op == OP_J) ? JUMP : FETCH;
   assign in_jump     = state_q == JUMP;
`else
   assign legal_op    = bus.op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI};
   assign decode_tail = FETCH;
   assign in_jump     = 1'b0;
`endif
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
         DECODE: state_d = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                           (bus.op == OP_R)    ? EXEC   :
                           (bus.op == OP_BEQ)  ? BRANCH :
                           (bus.op == OP_ADDI) ? ADDIEX : decode_tail;
         MEMADR: state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  state_d = bus.mem_ready ? MEMWB : MEMRD;
         MEMWR:  state_d = bus.mem_ready ? FETCH : MEMWR;
         EXEC:   state_d = RWB;
         ADDIEX: state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end
   assign in_fetch  = state_q == FETCH;
   assign in_decode = state_q == DECODE;
   assign in_memadr = state_q == MEMADR;
   assign in_memrd  = state_q == MEMRD;
   assign in_memwb  = state_q == MEMWB;
   assign in_memwr  = state_q == MEMWR;
   assign in_exec   = state_q == EXEC;
   assign in_rwb    = state_q == RWB;
   assign in_branch = state_q == BRANCH;
   assign in_addiex = state_q == ADDIEX;
   assign in_addiwb = state_q == ADDIWB;
   assign illegal   = in_decode & ~legal_op;
   // Everything is gated by rst_n so a mid-instruction reset drops all strobes at once.
   assign bus.pcwrite     = rst_n & ((in_fetch & bus.mem_ready) | in_jump);
   assign bus.pcwritecond = rst_n & in_branch;
   assign bus.iord        = rst_n & (in_memrd | in_memwr);
   assign bus.memread     = rst_n & (in_fetch | in_memrd);
   assign bus.memwrite    = rst_n & in_memwr;
   assign bus.irwrite     = rst_n & in_fetch & bus.mem_ready;
   assign bus.memtoreg    = rst_n & in_memwb;
   assign bus.regdst      = rst_n & in_rwb;
   assign bus.regwrite    = rst_n & (in_memwb | in_rwb | in_addiwb);
   assign bus.alusrca     = rst_n & (in_memadr | in_exec | in_branch | in_addiex);
   assign bus.alusrcb     = {2{rst_n}} & {in_decode | in_memadr | in_addiex, in_fetch | in_decode};
   assign bus.aluop       = {2{rst_n}} & {in_exec, in_branch};
   assign bus.pcsource    = {2{rst_n}} & {in_jump, in_branch};
   assign bus.instr_done  = rst_n & (in_memwb | in_rwb | in_branch | in_jump | in_addiwb |
                                     (in_memwr & bus.mem_ready) | illegal);
   assign bus.illegal_op  = rst_n & illegal;
   assign bus.state       = rst_n ? state_q : FETCH;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven cycle-by-cycle check of state and control outputs.
module tb_multicycle_control_unit;
   localparam logic [17:0] PCW = 18'(1) << 17;
   localparam logic [17:0] PWC = 18'(1) << 16;
   localparam logic [17:0] IOD = 18'(1) << 15;
   localparam logic [17:0] MRD = 18'(1) << 14;
   localparam logic [17:0] MWR = 18'(1) << 13;
   localparam logic [17:0] IRW = 18'(1) << 12;
   localparam logic [17:0] M2R = 18'(1) << 11;
   localparam logic [17:0] RDS = 18'(1) << 10;
   localparam logic [17:0] RGW = 18'(1) << 9;
   localparam logic [17:0] ASA = 18'(1) << 8;
   localparam logic [17:0] SB4 = 18'(1) << 6;
   localparam logic [17:0] SBI = 18'(2) << 6;
   localparam logic [17:0] SBS = 18'(3) << 6;
   localparam logic [17:0] AOS = 18'(1) << 4;
   localparam logic [17:0] AOF = 18'(2) << 4;
   localparam logic [17:0] PSO = 18'(1) << 2;
   localparam logic [17:0] PSJ = 18'(2) << 2;
   localparam logic [17:0] DON = 18'(1) << 1;
   localparam logic [17:0] ILL = 18'(1);
   localparam logic [17:0] FM1 = PCW | MRD | IRW | SB4;
   typedef struct {
      logic [5:0]  op;
      logic        mr;
      logic [3:0]  st;
      logic [17:0] ctl;
   } vec_t;
   typedef struct {
      logic [3:0]  st;
      logic [17:0] ctl;
      string       name;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;
   vec_t tbl[$];
   exp_t sb[$];
   multicycle_control_unit_if #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) bus ();
   multicycle_control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [17:0] ctl_now();
      return {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite, bus.irwrite,
              bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop,
              bus.pcsource, bus.instr_done, bus.illegal_op};
   endfunction
   function automatic void add(logic [5:0] op, logic mr, logic [3:0] st, logic [17:0] ctl);
      tbl.push_back('{op, mr, st, ctl});
   endfunction
   function automatic void expect_now(logic [3:0] st, logic [17:0] ctl, string name);
      sb.push_back('{st, ctl, name});
   endfunction
   task automatic check();
      exp_t e;
      e = sb.pop_front();
      n_run++;
      if (bus.state !== e.st || ctl_now() !== e.ctl) begin
         n_fail++;
         $display("FAIL %s: got state=%0d ctl=%b, need state=%0d ctl=%b",
                  e.name, bus.state, ctl_now(), e.st, e.ctl);
      end
   endtask
   task automatic step(vec_t v, string name);
      @(negedge clk);
      bus.op = v.op;
      bus.mem_ready = v.mr;
      expect_now(v.st, v.ctl, name);
      #1 check();
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, need finish before 100000");
      $fatal(1);
   end
   initial begin
      add(6'h00, 1'b1, 4'd1, SBS);
      add(6'h00, 1'b1, 4'd6, ASA | AOF);
      add(6'h00, 1'b1, 4'd7, RDS | RGW | DON);
      add(6'h23, 1'b1, 4'd0, FM1);
      add(6'h23, 1'b1, 4'd1, SBS);
      add(6'h23, 1'b1, 4'd2, ASA | SBI);
      add(6'h23, 1'b0, 4'd3, IOD | MRD);
      add(6'h23, 1'b0, 4'd3, IOD | MRD);
      add(6'h23, 1'b0, 4'd3, IOD | MRD);
      add(6'h23, 1'b1, 4'd3, IOD | MRD);
      add(6'h23, 1'b1, 4'd4, M2R | RGW | DON);
      add(6'h2b, 1'b1, 4'd0, FM1);
      add(6'h2b, 1'b1, 4'd1, SBS);
      add(6'h2b, 1'b1, 4'd2, ASA | SBI);
      add(6'h2b, 1'b1, 4'd5, IOD | MWR | DON);
      add(6'h04, 1'b1, 4'd0, FM1);
      add(6'h04, 1'b1, 4'd1, SBS);
      add(6'h04, 1'b1, 4'd8, ASA | AOS | PWC | PSO | DON);
      add(6'h08, 1'b0, 4'd0, MRD | SB4);
      add(6'h08, 1'b1, 4'd0, FM1);
      add(6'h08, 1'b1, 4'd1, SBS);
      add(6'h08, 1'b1, 4'd10, ASA | SBI);
      add(6'h08, 1'b1, 4'd11, RGW | DON);
      add(6'h2b, 1'b1, 4'd0, FM1);
      add(6'h2b, 1'b1, 4'd1, SBS);
      add(6'h2b, 1'b1, 4'd2, ASA | SBI);
      add(6'h2b, 1'b0, 4'd5, IOD | MWR);
      add(6'h2b, 1'b1, 4'd5, IOD | MWR | DON);
      add(6'h00, 1'b1, 4'd0, FM1);
      add(6'h00, 1'b0, 4'd1, SBS);
      add(6'h00, 1'b0, 4'd6, ASA | AOF);
      add(6'h00, 1'b0, 4'd7, RDS | RGW | DON);
      add(6'h3f, 1'b1, 4'd0, FM1);
      add(6'h3f, 1'b1, 4'd1, SBS | DON | ILL);
      add(6'h02, 1'b1, 4'd0, FM1);
`ifdef JUMP_EN
      add(6'h02, 1'b1, 4'd1, SBS);
      add(6'h02, 1'b1, 4'd9, PCW | PSJ | DON);
`else
      add(6'h02, 1'b1, 4'd1, SBS | DON | ILL);
`endif
      add(6'h00, 1'b1, 4'd0, FM1);
      add(6'h00, 1'b1, 4'd1, SBS);
      add(6'h00, 1'b1, 4'd6, ASA | AOF);
      bus.op = 6'h00;
      bus.mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      expect_now(4'd0, 18'd0, "rst_init_gated");
      #1 check();
      rst_n = 1'b1;
      expect_now(4'd0, FM1, "rst_release_fetch");
      #1 check();
      foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
      #1 rst_n = 1'b0;
      expect_now(4'd0, 18'd0, "rst_mid_exec_async");
      #1 check();
      @(posedge clk);
      expect_now(4'd0, 18'd0, "rst_mid_exec_hold");
      #1 check();
      @(negedge clk);
      rst_n = 1'b1;
      expect_now(4'd0, FM1, "rst_mid_exec_release");
      #1 check();
      step('{6'h00, 1'b1, 4'd1, SBS}, "post_reset_decode");
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style control FSM for the multicycle MIPS datapath. It replaces the single-cycle opcode decoder and sequences each instruction over 3–5 states sharing one ALU and one unified memory. It stalls on a memory-ready handshake and flags illegal opcodes. It sits between the instruction register's opcode field and the datapath mux/enable controls.

## Interface
- OPCODE_WIDTH, 6, width of the opcode field.
- STATE_WIDTH, 4, width of the state register and of the `state` debug port.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- op  input  OPCODE_WIDTH  opcode from the instruction register; sampled only in DECODE.
- mem_ready  input  1  memory has completed the current access (read data valid or write accepted).
- pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca  output  1 each  datapath controls.
- alusrcb  output  2  00 reg B; 01 const 4; 10 sign-ext imm; 11 sign-ext imm<<2.
- aluop  output  2  00 add; 01 subtract; 10 use funct.
- pcsource  output  2  00 ALU result; 01 ALUOut; 10 jump target.
- instr_done  output  1  high on the final cycle of each instruction.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- state  output  STATE_WIDTH  current state encoding, for debug.

## Operation
- Supported opcodes:
  - R-type: 000000
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - j: 000010 (present only with JUMP_EN)
  - addi: 001000
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Encodings 12–15 are unreachable; if entered, next state is FETCH.
- Outputs are decoded from the registered state only, except where a mem_ready qualifier is noted. Any control not listed for a state is 0.
- FETCH:
  - Outputs: memread=1, alusrcb=01, aluop=00, pcsource=00.
  - irwrite=pcwrite=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alusrcb=11, aluop=00.
  - Next state by opcode: lw/sw→MEMADR, R-type→EXEC, beq→BRANCH, j→JUMP, addi→ADDIEX.
  - Any other opcode→FETCH, with illegal_op=1 and instr_done=1.
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next: lw→MEMRD, sw→MEMWR. op is re-read from the instruction register, which holds stable.
- MEMRD: memread=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, instr_done=1. Next: FETCH.
- MEMWR: memwrite=1, iord=1. Hold until mem_ready, then go to FETCH. instr_done=mem_ready.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Next: RWB.
- RWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1. Next: FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, instr_done=1. Next: FETCH.
- JUMP: pcwrite=1, pcsource=10, instr_done=1. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1. Next: FETCH.
- memread and memwrite are never high together. During a stall, all outputs hold their state-decoded values.

## Timing
- Reset:
  - rst_n=0 forces state=FETCH asynchronously.
  - All outputs are combinationally gated to 0 while rst_n=0.
  - The first FETCH output cycle is the first cycle after rst_n rises.
- Reset asserted mid-instruction aborts it immediately: no further regwrite or memwrite, and no instr_done.
- Cycle counts with mem_ready held at 1:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Illegal opcode: 2 cycles.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every other state.
- illegal_op and instr_done each last exactly one cycle per instruction.

## Configuration
- JUMP_EN defined: j (000010) is decoded to the JUMP state.
- JUMP_EN undefined:
  - The JUMP state is not compiled in.
  - 000010 is handled as an illegal opcode: illegal_op pulse, return to FETCH.
  - pcsource never takes the value 10.

## Test plan
- Reset: rst_n low mid-EXEC → state=0 and all outputs 0 immediately. After release, memread=1 and alusrcb=01 on the next cycle.
- R-type, mem_ready=1: state sequence 0,1,6,7,0. regdst=regwrite=1 and instr_done=1 only in state 7.
- lw with mem_ready low for 3 cycles in MEMRD: sequence 0,1,2,3,3,3,3,4,0. memtoreg=regwrite=1 in state 4; total 8 cycles.
- sw then beq back-to-back:
  - sw: memwrite=1 with iord=1 in state 5; regwrite never asserted.
  - beq: pcwritecond=1, aluop=01, pcsource=01 in state 8.
- Opcode 111111: sequence 0,1,0. illegal_op=1 for one cycle in DECODE; no write strobes asserted.
- j with JUMP_EN defined: pcwrite=1 and pcsource=10 in state 9. Without JUMP_EN, the same stimulus produces an illegal_op pulse.
